// File: rtl/activity_pkg.sv
// Constants shared by the step front end and the high-activity time accumulator.
// The CLK_HZ pair selects simulation or hardware window length.
package activity_pkg;
  localparam int CNT_W_DFLT       = 16;
  localparam int HIGH_THRESH_DFLT = 64;
  localparam int CLK_HZ_SIM       = 100;
  localparam int CLK_HZ_HW        = 100_000_000;
endpackage

// File: rtl/pulse_sync_edge.sv
// Synchronizes an async level and emits a registered one-cycle pulse per rising edge.
// Latency STAGES+1 clk edges from first sample high; no backpressure.
module pulse_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic sig,
  output logic rise
);

  logic [STAGES-1:0] sync;
  logic              edge_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync   <= '0;
      edge_q <= 1'b0;
      rise   <= 1'b0;
    end else begin
      sync   <= {sync[STAGES-2:0], sig};
      edge_q <= sync[STAGES-1];
      rise   <= sync[STAGES-1] & ~edge_q;
    end
  end

endmodule

// File: rtl/step_rate_window.sv
// Step strobe, one-second tick, per-window step count with high-activity flag, saturating total.
// Strobe lags step_in by SYNC_STAGES+1 edges; window results update on the tick edge; no backpressure.
module step_rate_window
  import activity_pkg::*;
#(
  parameter int CLK_HZ      = CLK_HZ_HW,
  parameter int HIGH_THRESH = HIGH_THRESH_DFLT,
  parameter int CNT_W       = CNT_W_DFLT,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             step_in,
  output logic             step_strobe,
  output logic             sec_tick,
  output logic [CNT_W-1:0] steps_last_sec,
  output logic             high_sec,
  output logic [CNT_W-1:0] step_total
);

  localparam int               DIV_W     = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_HZ - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] THRESH    = CNT_W'(HIGH_THRESH);
  // A threshold wider than the counter can never be met; keep the flag low.
  localparam bit               THRESH_OK = (longint'(HIGH_THRESH) <= ((longint'(1) << CNT_W) - 1));

  logic [DIV_W-1:0] div_cnt;
  logic [CNT_W-1:0] win_cnt;
  logic [CNT_W-1:0] closed;

  pulse_sync_edge #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .sig   (step_in),
    .rise  (step_strobe)
  );

  assign sec_tick = (div_cnt == DIV_LAST);

  // Window count including this cycle's strobe, so a strobe on the tick lands in the closing window.
  always_comb begin
    closed = win_cnt;
    if (step_strobe && (win_cnt != CNT_MAX)) begin
      closed = win_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt        <= '0;
      win_cnt        <= '0;
      steps_last_sec <= '0;
      high_sec       <= 1'b0;
      step_total     <= '0;
    end else begin
      div_cnt <= sec_tick ? '0 : div_cnt + DIV_W'(1);
      if (sec_tick) begin
        steps_last_sec <= closed;
        high_sec       <= THRESH_OK && (closed >= THRESH);
        win_cnt        <= '0;
      end else begin
        win_cnt <= closed;
      end
      if (step_strobe && (step_total != CNT_MAX)) begin
        step_total <= step_total + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_step_rate_window.sv
// Directed bench: dut0 100-cycle window, dut1 400-cycle window for threshold edges,
// dut2 CNT_W=4 for saturation. All share clk and reset.
module tb_step_rate_window;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  step = 3'b000;
  logic [2:0]  tick;
  logic [2:0]  strobe;
  logic [2:0]  high;
  logic [15:0] last0, last1, total0, total1;
  logic [3:0]  last2, total2;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  step_rate_window #(.CLK_HZ(100), .HIGH_THRESH(64), .CNT_W(16), .SYNC_STAGES(2)) dut0 (
    .clk(clk), .reset(reset), .step_in(step[0]), .step_strobe(strobe[0]), .sec_tick(tick[0]),
    .steps_last_sec(last0), .high_sec(high[0]), .step_total(total0));

  step_rate_window #(.CLK_HZ(400), .HIGH_THRESH(64), .CNT_W(16), .SYNC_STAGES(2)) dut1 (
    .clk(clk), .reset(reset), .step_in(step[1]), .step_strobe(strobe[1]), .sec_tick(tick[1]),
    .steps_last_sec(last1), .high_sec(high[1]), .step_total(total1));

  step_rate_window #(.CLK_HZ(100), .HIGH_THRESH(8), .CNT_W(4), .SYNC_STAGES(2)) dut2 (
    .clk(clk), .reset(reset), .step_in(step[2]), .step_strobe(strobe[2]), .sec_tick(tick[2]),
    .steps_last_sec(last2), .high_sec(high[2]), .step_total(total2));

  typedef struct {
    int pulses;
    int exp_steps;
    int exp_high;
  } win_vec_t;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called just after a posedge; returns just after a posedge.
  task automatic pulse(input int d, input int hi, input int lo);
    step[d] = 1'b1;
    repeat (hi) @(posedge clk);
    #1 step[d] = 1'b0;
    repeat (lo) @(posedge clk);
    #1;
  endtask

  // Returns on the negedge inside the next sec_tick cycle of dut d.
  task automatic wait_tick(input int d);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 1000 && !seen; i++) begin
      @(negedge clk);
      if (tick[d]) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL wait_tick_dut%0d: no sec_tick in 1000 cycles, required one", d);
    end
  endtask

  initial begin
    win_vec_t tbl[4];
    int hits, spurious, nstrobe, lat, rel;

    tbl[0] = '{63, 63, 0};
    tbl[1] = '{64, 64, 1};
    tbl[2] = '{0, 0, 0};
    tbl[3] = '{1, 1, 0};

    // Reset and idle
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_last", last0, 0);
    chk("rst_total", total0, 0);
    chk("rst_flags", {tick, strobe, high}, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    hits = 0;
    spurious = 0;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      if (tick[0]) begin
        if (c % 100 == 0) hits++;
        else spurious++;
      end
    end
    chk("idle_ticks_at_100_200_300", hits, 3);
    chk("idle_spurious_ticks", spurious, 0);
    @(posedge clk);
    #1;
    chk("idle_last", last0, 0);
    chk("idle_high", high[0], 0);

    // Threshold edges on the 400-cycle window
    wait_tick(1);
    @(posedge clk);
    #1;
    for (int v = 0; v < 4; v++) begin
      for (int p = 0; p < tbl[v].pulses; p++) pulse(1, 2, 2);
      wait_tick(1);
      @(posedge clk);
      #1;
      chk($sformatf("thr%0d_steps", v), last1, tbl[v].exp_steps);
      chk($sformatf("thr%0d_high", v), high[1], tbl[v].exp_high);
    end
    chk("thr_total", total1, 128);

    // Level held high: one strobe, three edges after the rise
    @(posedge clk);
    #1 step[0] = 1'b1;
    nstrobe = 0;
    lat = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (i == 50) step[0] = 1'b0;
      if (strobe[0]) begin
        nstrobe++;
        if (lat < 0) lat = i;
      end
    end
    chk("level_strobes", nstrobe, 1);
    chk("level_latency", lat, 3);
    chk("level_total", total0, 1);

    // Strobe coinciding with the tick after 10 strobes
    wait_tick(0);
    @(posedge clk);
    #1;
    for (int p = 0; p < 10; p++) pulse(0, 2, 2);
    repeat (56) @(posedge clk);
    #1 step[0] = 1'b1;
    repeat (2) @(posedge clk);
    #1 step[0] = 1'b0;
    wait_tick(0);
    chk("coinc_strobe_on_tick", strobe[0], 1);
    @(posedge clk);
    #1;
    chk("coinc_steps", last0, 11);
    chk("coinc_high", high[0], 0);
    pulse(0, 2, 2);
    wait_tick(0);
    @(posedge clk);
    #1;
    chk("next_window_steps", last0, 1);
    chk("next_window_total", total0, 13);

    // Reset at cycle 60 of a window holding 30 steps
    wait_tick(0);
    @(posedge clk);
    #1;
    for (int p = 0; p < 30; p++) pulse(0, 1, 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_last", last0, 0);
    chk("midrst_total", total0, 0);
    chk("midrst_flags", {tick[0], strobe[0], high[0]}, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    rel = cyc;
    fork
      begin
        for (int p = 0; p < 5; p++) pulse(0, 2, 2);
      end
      begin
        for (int p = 0; p < 20; p++) pulse(2, 2, 2);
      end
    join
    wait_tick(0);
    chk("midrst_tick_cycle", cyc - rel + 1, 100);
    @(posedge clk);
    #1;
    chk("midrst_steps", last0, 5);
    chk("midrst_total_after", total0, 5);
    chk("sat_steps", last2, 15);
    chk("sat_total", total2, 15);
    chk("sat_high", high[2], 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
